// File: rtl/sludge_io_pkg.sv
// rtl/sludge_io_pkg.sv - event code types shared by the display and button I/O paths
package sludge_io_pkg;
  localparam int CODE_W = 32;
  typedef logic [CODE_W-1:0] btn_code_t;
  localparam btn_code_t CODE_NONE = 32'd0;

  function automatic btn_code_t btn_to_code(input logic [7:0] idx);
    return btn_code_t'(idx) + btn_code_t'(1);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser and stability-counter debounce for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise_pulse = level & ~level_d;
endmodule

// File: rtl/button_input_controller.sv
// rtl/button_input_controller.sv - debounced buttons turned into queued 32-bit event codes
// Define BUTTON_AUTO_REPEAT_EN to re-issue codes while a button stays held.
module button_input_controller
  import sludge_io_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_in,
  input  logic                rd_en,
  output logic [CODE_W-1:0]   reg_out,
  output logic                valid,
  output logic                overflow
);
  localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] rep_hit;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] pick_mask;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               do_pop;
  logic               do_push;
  btn_code_t          new_code;
  btn_code_t          mem [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [PW:0]        count;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock      (clock),
      .reset      (reset),
      .raw        (btn_in[i]),
      .level      (level[i]),
      .rise_pulse (rise[i])
    );
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  logic [RW-1:0] rep_cnt [NUM_BTN];

  // The counter restarts on the press itself, so the first repeat lands REPEAT_CYCLES after the press push.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < NUM_BTN; i++)
      rep_hit[i] = level[i] & ~rise[i] & (rep_cnt[i] == RW'(REPEAT_CYCLES - 1));
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (reset || !level[i] || rise[i] || rep_hit[i]) rep_cnt[i] <= '0;
      else rep_cnt[i] <= rep_cnt[i] + RW'(1);
    end
  end
`else
  logic unused_level;
  assign unused_level = ^level;
  assign rep_hit = '0;
`endif

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  assign pick_mask = pick_valid ? (NUM_BTN'(1) << pick_idx) : '0;
  assign new_code  = btn_to_code(8'(pick_idx));
  assign do_pop    = rd_en && valid;
  assign do_push   = pick_valid && ((count != FULL) || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= new_code;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      reg_out  <= CODE_NONE;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // The picked flag clears whether or not the code fits in the queue.
      pending <= (pending & ~pick_mask) | rise | rep_hit;
      if (pick_valid && !do_push) overflow <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (count > (PW+1)'(1)) begin
          reg_out <= mem[rd_ptr + PW'(1)];
          valid   <= 1'b1;
        end else if (do_push) begin
          reg_out <= new_code;
          valid   <= 1'b1;
        end else begin
          reg_out <= CODE_NONE;
          valid   <= 1'b0;
        end
      end else if (count == '0 && do_push) begin
        reg_out <= new_code;
        valid   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_button_input_controller.sv
// tb/tb_button_input_controller.sv - scoreboard bench for button_input_controller
module tb_button_input_controller;
  import sludge_io_pkg::*;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int FD = 4;
  localparam int RC = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            rd_en;
  logic [NB-1:0]   btn_in;
  logic [31:0]     reg_out;
  logic            valid;
  logic            overflow;

  int              n_cmp = 0;
  int              n_bad = 0;
  btn_code_t       exp_q[$];
  btn_code_t       exp_code;
  logic            model_ovf;

  always #5 clock = ~clock;

  button_input_controller #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD), .REPEAT_CYCLES(RC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_in   (btn_in),
    .rd_en    (rd_en),
    .reg_out  (reg_out),
    .valid    (valid),
    .overflow (overflow)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset;
    btn_in = '0;
    rd_en  = 1'b0;
    reset  = 1'b1;
    idle(2);
    reset  = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic model_push(input btn_code_t code);
    if (exp_q.size() < FD) exp_q.push_back(code);
    else model_ovf = 1'b1;
  endtask

  task automatic press_release(input int b);
    btn_in = NB'(1) << b;
    model_push(btn_to_code(8'(b)));
    idle(10);
    btn_in = '0;
    idle(10);
  endtask

  task automatic test_reset;
    btn_in = '0;
    rd_en  = 1'b0;
    reset  = 1'b1;
    idle(2);
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b expected 0", valid); end
    n_cmp++;
    if (reg_out !== CODE_NONE) begin n_bad++; $display("FAIL reset_reg_out got %0d expected 0", reg_out); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_latency;
    apply_reset();
    btn_in = 4'b0010;
    model_push(btn_to_code(8'd1));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k < 8) begin
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL latency_early k=%0d valid got %b expected 0", k, valid); end
      end
    end
    exp_code = exp_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || reg_out !== exp_code)
      begin n_bad++; $display("FAIL latency_cycle8 valid=%b reg_out=%0d expected valid=1 reg_out=%0d", valid, reg_out, exp_code); end
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || reg_out !== CODE_NONE)
      begin n_bad++; $display("FAIL latency_pop valid=%b reg_out=%0d expected valid=0 reg_out=0", valid, reg_out); end
    btn_in = '0;
    idle(12);
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL release_no_event valid got %b expected 0", valid); end
  endtask

  task automatic test_glitch;
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      btn_in[0] = ((c % 6) < 3);
      rd_en     = ((c % 6) == 4);
      @(negedge clock);
      n_cmp++;
      if (valid !== 1'b0 || reg_out !== CODE_NONE)
        begin n_bad++; $display("FAIL glitch c=%0d valid=%b reg_out=%0d expected valid=0 reg_out=0", c, valid, reg_out); end
    end
    btn_in = '0;
    rd_en  = 1'b0;
    idle(10);
    n_cmp++;
    if (valid !== 1'b0 || overflow !== 1'b0)
      begin n_bad++; $display("FAIL glitch_settle valid=%b overflow=%b expected 0 0", valid, overflow); end
    btn_in[0] = 1'b1;
    model_push(btn_to_code(8'd0));
    idle(DB);
    btn_in[0] = 1'b0;
    for (int c = 0; c < 20 && valid !== 1'b1; c++) @(negedge clock);
    exp_code = exp_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || reg_out !== exp_code)
      begin n_bad++; $display("FAIL min_pulse valid=%b reg_out=%0d expected valid=1 reg_out=%0d", valid, reg_out, exp_code); end
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    idle(10);
  endtask

  task automatic test_simultaneous;
    apply_reset();
    btn_in = 4'b1011;
    model_push(btn_to_code(8'd0));
    model_push(btn_to_code(8'd1));
    model_push(btn_to_code(8'd3));
    for (int c = 0; c < 20 && valid !== 1'b1; c++) @(negedge clock);
    for (int n = 0; n < 3; n++) begin
      exp_code = exp_q.pop_front();
      n_cmp++;
      if (valid !== 1'b1 || reg_out !== exp_code)
        begin n_bad++; $display("FAIL simul_pop%0d valid=%b reg_out=%0d expected valid=1 reg_out=%0d", n, valid, reg_out, exp_code); end
      rd_en = 1'b1;
      @(negedge clock);
    end
    rd_en = 1'b0;
    n_cmp++;
    if (valid !== 1'b0 || reg_out !== CODE_NONE)
      begin n_bad++; $display("FAIL simul_empty valid=%b reg_out=%0d expected valid=0 reg_out=0", valid, reg_out); end
    btn_in = '0;
    idle(10);
  endtask

  task automatic test_overflow;
    int seq [6];
    seq = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    for (int p = 0; p < 6; p++) begin
      press_release(seq[p]);
      n_cmp++;
      if (overflow !== model_ovf)
        begin n_bad++; $display("FAIL overflow_press%0d got %b expected %b", p, overflow, model_ovf); end
    end
    for (int n = 0; n < FD; n++) begin
      exp_code = exp_q.pop_front();
      n_cmp++;
      if (valid !== 1'b1 || reg_out !== exp_code)
        begin n_bad++; $display("FAIL ovf_drain%0d valid=%b reg_out=%0d expected valid=1 reg_out=%0d", n, valid, reg_out, exp_code); end
      rd_en = 1'b1;
      @(negedge clock);
    end
    rd_en = 1'b0;
    idle(2);
    n_cmp++;
    if (valid !== 1'b0 || overflow !== 1'b1)
      begin n_bad++; $display("FAIL ovf_after_drain valid=%b overflow=%b expected valid=0 overflow=1", valid, overflow); end
  endtask

  task automatic test_full_push_pop;
    apply_reset();
    for (int b = 0; b < NB; b++) press_release(b);
    btn_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 7) begin
        exp_code = exp_q.pop_front();
        n_cmp++;
        if (valid !== 1'b1 || reg_out !== exp_code)
          begin n_bad++; $display("FAIL full_head valid=%b reg_out=%0d expected valid=1 reg_out=%0d", valid, reg_out, exp_code); end
        rd_en = 1'b1;
        model_push(btn_to_code(8'd0));
      end
    end
    rd_en  = 1'b0;
    btn_in = '0;
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_push_pop_overflow got %b expected 0", overflow); end
    for (int n = 0; n < FD; n++) begin
      exp_code = exp_q.pop_front();
      n_cmp++;
      if (valid !== 1'b1 || reg_out !== exp_code)
        begin n_bad++; $display("FAIL full_drain%0d valid=%b reg_out=%0d expected valid=1 reg_out=%0d", n, valid, reg_out, exp_code); end
      rd_en = 1'b1;
      @(negedge clock);
    end
    rd_en = 1'b0;
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL full_drain_empty valid got %b expected 0", valid); end
    idle(10);
  endtask

  task automatic test_reset_mid;
    apply_reset();
    btn_in = 4'b1100;
    model_push(btn_to_code(8'd2));
    model_push(btn_to_code(8'd3));
    for (int c = 0; c < 20 && valid !== 1'b1; c++) @(negedge clock);
    idle(3);
    n_cmp++;
    if (valid !== 1'b1 || reg_out !== exp_q[0])
      begin n_bad++; $display("FAIL mid_queued valid=%b reg_out=%0d expected valid=1 reg_out=%0d", valid, reg_out, exp_q[0]); end
    btn_in = 4'b1000;
    reset  = 1'b1;
    @(negedge clock);
    exp_q.delete();
    n_cmp++;
    if (valid !== 1'b0 || reg_out !== CODE_NONE || overflow !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset valid=%b reg_out=%0d overflow=%b expected 0 0 0", valid, reg_out, overflow); end
    reset = 1'b0;
    model_push(btn_to_code(8'd3));
    for (int c = 0; c < 20 && valid !== 1'b1; c++) @(negedge clock);
    exp_code = exp_q.pop_front();
    n_cmp++;
    if (valid !== 1'b1 || reg_out !== exp_code)
      begin n_bad++; $display("FAIL held_through_reset valid=%b reg_out=%0d expected valid=1 reg_out=%0d", valid, reg_out, exp_code); end
    rd_en  = 1'b1;
    @(negedge clock);
    rd_en  = 1'b0;
    btn_in = '0;
    idle(12);
    n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL held_single_event valid got %b expected 0", valid); end
  endtask

`ifdef BUTTON_AUTO_REPEAT_EN
  task automatic test_repeat;
    apply_reset();
    btn_in = 4'b1000;
    model_push(btn_to_code(8'd3));
    for (int k = 1; k <= 41; k++) begin
      @(negedge clock);
      rd_en = 1'b0;
      if (k == 8 || k == 24 || k == 40) begin
        exp_code = exp_q.pop_front();
        n_cmp++;
        if (valid !== 1'b1 || reg_out !== exp_code)
          begin n_bad++; $display("FAIL repeat_k%0d valid=%b reg_out=%0d expected valid=1 reg_out=%0d", k, valid, reg_out, exp_code); end
        rd_en = 1'b1;
        if (k < 40) model_push(btn_to_code(8'd3));
      end else if (k == 23 || k == 39) begin
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL repeat_early_k%0d valid got %b expected 0", k, valid); end
      end
    end
    rd_en  = 1'b0;
    btn_in = '0;
    idle(12);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    rd_en  = 1'b0;
    btn_in = '0;
    model_ovf = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
`ifdef BUTTON_AUTO_REPEAT_EN
    test_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
